dircc_avalon_st_packet_router: RTL
==================================

DIRCC_AVALON_ST_PACKET_ROUTER -- requirements
Module: dircc_avalon_st_packet_router

Interface
REQ-001 Parameter BITS_PER_SYMBOL, default 8, bits per Avalon-ST symbol.
REQ-002 Parameter SYMBOLS_PER_BEAT, default 4, symbols per beat; DATA_WIDTH = product, EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT).
REQ-003 Parameter ADDRESS_MEM_WIDTH, default 32, hardware address width.
REQ-004 Parameter BROADCAST_ADDR, default 32'hFFFF_FFFF, destination delivered to both outputs.
REQ-005 clk  input  1  single clock; reset_n  input  1  asynchronous active-low reset.
REQ-006 input_data/input_empty/input_startofpacket/input_endofpacket/input_valid  input  DATA_WIDTH/EMPTY_WIDTH/1/1/1  packet stream from a processing node; input_ready  output  1.
REQ-007 local_data/local_empty/local_startofpacket/local_endofpacket/local_valid  output  same widths  loopback stream; local_ready  input  1.
REQ-008 net_data/net_empty/net_startofpacket/net_endofpacket/net_valid  output  same widths  network stream; net_ready  input  1.
REQ-009 address  input  ADDRESS_MEM_WIDTH  this node's hardware address, stable outside reset.
REQ-010 drop_count  output  16  count of dropped beats (present only with DIRCC_ROUTER_DROP_COUNT_EN).

Function
REQ-011 The first beat of every packet SHALL carry the destination hardware address in input_data[ADDRESS_MEM_WIDTH-1:0].
REQ-012 States SHALL be IDLE, FORWARD, DROP; reset enters IDLE.
REQ-013 In IDLE, an accepted beat with startofpacket SHALL latch the route: dest == address -> LOCAL; dest == BROADCAST_ADDR -> BOTH; otherwise NET.
REQ-014 In IDLE, an accepted beat without startofpacket SHALL be discarded, increment drop_count, and enter DROP unless endofpacket is also set.
REQ-015 DROP SHALL accept (input_ready=1) and discard beats until a beat with endofpacket, then return to IDLE.
REQ-016 Each output SHALL hold a one-beat register; an accepted beat SHALL appear on the routed output(s) with valid asserted exactly one cycle after acceptance.
REQ-017 input_ready SHALL be 1 in IDLE/FORWARD only when every routed output register is empty or is being drained this cycle (valid && ready); in IDLE the route is taken from the beat being presented.
REQ-018 For BOTH, a beat SHALL be accepted only when both registers can accept; each output clears its valid independently on its own ready.
REQ-019 An accepted beat with endofpacket SHALL return FORWARD to IDLE; a single-beat packet (sop and eop together) SHALL pass from IDLE back to IDLE.
REQ-020 data, empty, sop, eop SHALL be forwarded unmodified; beats SHALL never be reordered, duplicated (except BOTH) or lost while not in DROP.
REQ-021 Output valid SHALL stay asserted with stable data until the matching ready is seen.
REQ-022 A second startofpacket while in FORWARD SHALL be forwarded on the current route without re-routing; the protocol violation is not corrected.
REQ-023 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-024 On reset_n low, asynchronously: state IDLE, route NET, all output valid/data/empty/sop/eop 0, input_ready 0, drop_count 0.
REQ-025 Reset mid-packet SHALL discard any held beats; the first post-reset beat is treated as a new packet header.

Configuration
REQ-026 With DIRCC_ROUTER_DROP_COUNT_EN defined, drop_count port and counter SHALL exist and count each discarded beat; without it, the port and counter SHALL be absent and drop behaviour is otherwise identical.

Structure
REQ-027 The route enum (ROUTE_LOCAL, ROUTE_NET, ROUTE_BOTH), state enum, and BROADCAST_ADDR default SHALL reside in dircc_types_pkg.
REQ-028 The one-beat output register SHALL be a sub-module dircc_avalon_st_beat_reg, instantiated twice.

Verification
REQ-029 address=5, 3-beat packet dest=5, both readies 1 -> 3 beats on local one cycle later each, net_valid never 1.
REQ-030 dest=9, net_ready held 0 for 4 cycles after first beat -> input_ready 0 after one beat, no beat lost, order preserved once ready.
REQ-031 dest=32'hFFFF_FFFF, local_ready toggling, net_ready 1 -> identical 2-beat packet on both outputs, input stalls while local register full.
REQ-032 Beat without sop in IDLE, then 2 beats ending with eop, then valid packet dest=5 -> 3 beats dropped, drop_count=3 (macro on), next packet delivered to local.
REQ-033 Single-beat packet (sop=eop=1, empty=2) dest=7 -> net gets one beat with empty=2, state back to IDLE.
REQ-034 reset_n asserted mid-packet with net_valid=1 -> all valids 0 immediately; post-reset sop beat routed correctly.

Source files
------------

// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC Avalon-ST packet router: route and state
// encodings plus the default broadcast destination.
package dircc_types_pkg;

  typedef enum logic [1:0] {
    ROUTE_LOCAL = 2'd0,
    ROUTE_NET   = 2'd1,
    ROUTE_BOTH  = 2'd2
  } route_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [31:0] BROADCAST_ADDR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/dircc_avalon_st_beat_reg.sv
// One-beat Avalon-ST output holding register. A beat is loaded only when
// the register is empty or draining, so a held beat never changes while
// valid is asserted.
module dircc_avalon_st_beat_reg #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [EMPTY_WIDTH-1:0] wr_empty,
  input  logic                   wr_sop,
  input  logic                   wr_eop,
  output logic                   can_load,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [EMPTY_WIDTH-1:0] empty,
  output logic                   startofpacket,
  output logic                   endofpacket,
  output logic                   valid,
  input  logic                   ready
);

  assign can_load = !valid || ready;

  // Capture a new beat on load; otherwise release the beat once it is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid         <= 1'b0;
      data          <= '0;
      empty         <= '0;
      startofpacket <= 1'b0;
      endofpacket   <= 1'b0;
    end else if (load) begin
      valid         <= 1'b1;
      data          <= wr_data;
      empty         <= wr_empty;
      startofpacket <= wr_sop;
      endofpacket   <= wr_eop;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dircc_avalon_st_packet_router.sv
// DIRCC Avalon-ST packet router. Routes each packet by the destination
// address in its header beat to the local loopback port, the network port,
// or both (broadcast). Optional feature macro: DIRCC_ROUTER_DROP_COUNT_EN
// adds a saturating drop_count output counting discarded beats.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a header beat; route taken from presented beat
// ST_FORWARD | mid-packet, forwarding beats on the latched route
// ST_DROP    | discarding an orphan packet body until endofpacket
module dircc_avalon_st_packet_router
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL   = 8,
  parameter int SYMBOLS_PER_BEAT  = 4,
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter logic [ADDRESS_MEM_WIDTH-1:0] BROADCAST_ADDR =
    ADDRESS_MEM_WIDTH'(BROADCAST_ADDR_DEFAULT),
  localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic [DATA_WIDTH-1:0]        input_data,
  input  logic [EMPTY_WIDTH-1:0]       input_empty,
  input  logic                         input_startofpacket,
  input  logic                         input_endofpacket,
  input  logic                         input_valid,
  output logic                         input_ready,

  output logic [DATA_WIDTH-1:0]        local_data,
  output logic [EMPTY_WIDTH-1:0]       local_empty,
  output logic                         local_startofpacket,
  output logic                         local_endofpacket,
  output logic                         local_valid,
  input  logic                         local_ready,

  output logic [DATA_WIDTH-1:0]        net_data,
  output logic [EMPTY_WIDTH-1:0]       net_empty,
  output logic                         net_startofpacket,
  output logic                         net_endofpacket,
  output logic                         net_valid,
  input  logic                         net_ready,

`ifdef DIRCC_ROUTER_DROP_COUNT_EN
  output logic [15:0]                  drop_count,
`endif
  input  logic [ADDRESS_MEM_WIDTH-1:0] address
);

  state_t state_q;
  route_t route_q;
  route_t header_route;
  route_t cur_route;
  logic   run_q;
  logic   local_can;
  logic   net_can;
  logic   need_local;
  logic   need_net;
  logic   accept;
  logic   forward;
  logic   load_local;
  logic   load_net;
  logic [ADDRESS_MEM_WIDTH-1:0] dest;

  assign dest = input_data[ADDRESS_MEM_WIDTH-1:0];

  // Route decode for the beat currently presented, and the route in effect.
  always_comb begin
    header_route = ROUTE_NET;
    if (dest == address)
      header_route = ROUTE_LOCAL;
    else if (dest == BROADCAST_ADDR)
      header_route = ROUTE_BOTH;
    cur_route = (state_q == ST_IDLE) ? header_route : route_q;
  end

  assign need_local = (cur_route == ROUTE_LOCAL) || (cur_route == ROUTE_BOTH);
  assign need_net   = (cur_route == ROUTE_NET)   || (cur_route == ROUTE_BOTH);

  // run_q holds ready low through reset and the first cycle after it.
  assign input_ready = run_q &&
                       ((state_q == ST_DROP) ||
                        ((!need_local || local_can) && (!need_net || net_can)));

  assign accept     = input_valid && input_ready;
  assign forward    = accept && ((state_q == ST_FORWARD) ||
                                 ((state_q == ST_IDLE) && input_startofpacket));
  assign load_local = forward && need_local;
  assign load_net   = forward && need_net;

  // Packet-level state machine: route latch on header, drop orphan bodies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      route_q <= ROUTE_NET;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (input_startofpacket) begin
              route_q <= header_route;
              state_q <= input_endofpacket ? ST_IDLE : ST_FORWARD;
            end else begin
              state_q <= input_endofpacket ? ST_IDLE : ST_DROP;
            end
          end
          ST_FORWARD: if (input_endofpacket) state_q <= ST_IDLE;
          ST_DROP:    if (input_endofpacket) state_q <= ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DIRCC_ROUTER_DROP_COUNT_EN
  logic drop_beat;
  assign drop_beat = accept && !forward;

  // Saturating count of every discarded beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_count <= 16'd0;
    else if (drop_beat && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end
`endif

  dircc_avalon_st_beat_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .EMPTY_WIDTH (EMPTY_WIDTH)
  ) u_local_reg (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load_local),
    .wr_data       (input_data),
    .wr_empty      (input_empty),
    .wr_sop        (input_startofpacket),
    .wr_eop        (input_endofpacket),
    .can_load      (local_can),
    .data          (local_data),
    .empty         (local_empty),
    .startofpacket (local_startofpacket),
    .endofpacket   (local_endofpacket),
    .valid         (local_valid),
    .ready         (local_ready)
  );

  dircc_avalon_st_beat_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .EMPTY_WIDTH (EMPTY_WIDTH)
  ) u_net_reg (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load_net),
    .wr_data       (input_data),
    .wr_empty      (input_empty),
    .wr_sop        (input_startofpacket),
    .wr_eop        (input_endofpacket),
    .can_load      (net_can),
    .data          (net_data),
    .empty         (net_empty),
    .startofpacket (net_startofpacket),
    .endofpacket   (net_endofpacket),
    .valid         (net_valid),
    .ready         (net_ready)
  );

endmodule
